mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported backing memory between instruction fetch (IF) and the MEM-stage
//  load/store port of the 5-stage MIPS pipeline. Sits between the PC/imem fetch path and the
//  memory stage, and returns per-requester completion pulses.
//  Generates the fetch and data stall signals that the pipeline uses to hold its stage registers.
// PARAMETERS
//  DWIDTH        32  data width of the fetch and load/store paths
//  PC_WIDTH      32  byte address width of both requesters and of the memory
//  STARVE_LIMIT  4   consecutive DM grants, while IF is pending, before IF is forced to win
// PORTS
//  ma_clk          in   1         clock
//  ma_rst          in   1         synchronous, active-high reset
//  ma_i_if_req     in   1         fetch request; held high until ma_o_if_valid
//  ma_i_if_addr    in   PC_WIDTH  fetch address; stable while ma_i_if_req is high
//  ma_i_if_flush   in   1         squash the in-flight or pending fetch (branch/jump taken)
//  ma_o_if_valid   out  1         one-cycle pulse: ma_o_if_instr is valid
//  ma_o_if_instr   out  DWIDTH    fetched word
//  ma_o_if_stall   out  1         ma_i_if_req & ~ma_o_if_valid
//  ma_i_dm_req     in   1         load/store request; held high until ma_o_dm_valid
//  ma_i_dm_we      in   1         1 = store, 0 = load
//  ma_i_dm_addr    in   PC_WIDTH  data address
//  ma_i_dm_mask    in   4         byte enables (from treatstore)
//  ma_i_dm_wdata   in   DWIDTH    store data
//  ma_o_dm_valid   out  1         one-cycle completion pulse
//  ma_o_dm_rdata   out  DWIDTH    load data; 0 for stores
//  ma_o_dm_stall   out  1         ma_i_dm_req & ~ma_o_dm_valid
//  ma_o_mem_req    out  1         memory request; level, held until ma_i_mem_ready
//  ma_o_mem_we / ma_o_mem_addr / ma_o_mem_mask / ma_o_mem_wdata  out  1/PC_WIDTH/4/DWIDTH
//  ma_i_mem_ready  in   1         one-cycle pulse: access done, ma_i_mem_rdata valid
//  ma_i_mem_rdata  in   DWIDTH    read data
// BEHAVIOUR
//  - Reset: state IDLE. All ma_o_* outputs are 0, starve_cnt = 0, discard = 0. Reset mid-access
//    drops ma_o_mem_req the next cycle and abandons the access with no valid pulse.
//  - FSM states: IDLE, IF_WAIT, DM_WAIT. All outputs except the two stalls are registered.
//  - IDLE, with a request present: grant it, latch the request onto ma_o_mem_*, and raise
//    ma_o_mem_req in the next cycle. The state goes to IF_WAIT or DM_WAIT.
//  - Priority: DM wins, unless starve_cnt == STARVE_LIMIT and ma_i_if_req is high; then IF wins.
//  - starve_cnt: increments on each DM grant made while ma_i_if_req is high, and saturates at
//    STARVE_LIMIT. It clears on an IF grant or on any cycle where ma_i_if_req is low.
//  - *_WAIT: ma_o_mem_* are held stable. When ma_i_mem_ready is seen, ma_o_mem_req drops and
//    the state returns to IDLE.
//  - Completion: the cycle after ready, the matching valid pulses for 1 cycle, carrying data
//    registered from ma_i_mem_rdata.
//  - Latency: request seen at cycle T -> mem_req high at T+1 -> ready at T+k -> valid at T+k+1.
//    The next grant is made no earlier than T+k+1, so an access occupies at least 3 cycles.
//  - Flush:
//      - In IF_WAIT, flush sets discard. The access still completes on the memory side, but
//        ma_o_if_valid is suppressed.
//      - In IDLE, flush blocks the IF grant for that cycle.
//      - discard clears on leaving IF_WAIT.
//  - ma_i_mem_ready in IDLE is ignored.
//  - A requester dropping its req before valid is a protocol error, except IF under flush;
//    the arbiter still completes the access.
//  - Simultaneous DM valid and a new DM req in the same cycle: the new req is treated as a new
//    request and is granted from IDLE.
// STRUCTURE
//  - DWIDTH, PC_WIDTH and the state encodings (MA_IDLE=2'd0, MA_IF_WAIT=2'd1, MA_DM_WAIT=2'd2)
//    live in the shared defines header.
//  - One natural sub-module: arb_starve_counter (saturating counter: inc, clr, at_limit).
// TESTING
//  1. Reset with both reqs high -> all outputs 0. Release reset -> DM granted first:
//     mem_addr = dm_addr and mem_req high at the 2nd cycle after reset release.
//  2. IF-only fetch at 0x40, memory ready after 2 cycles with 0x2001000A
//     -> if_valid pulse with if_instr = 0x2001000A; if_stall high until that pulse.
//  3. Store: addr 0x10, mask 4'b0011, wdata 0xBEEF -> mem_we = 1 with those values held;
//     dm_valid pulse with dm_rdata = 0.
//  4. Both reqs continuously high, STARVE_LIMIT = 4 -> grant sequence DM,DM,DM,DM,IF,DM,...
//  5. Flush asserted during IF_WAIT -> mem completes, no if_valid.
//     The next IF req to 0x80 returns its own data.
//  6. ma_rst pulsed while in DM_WAIT -> mem_req low next cycle, no dm_valid, state IDLE.
//     A stray mem_ready afterwards is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and FSM encodings for the IF / MEM-stage memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int MA_DWIDTH   = 32;
  localparam int MA_PC_WIDTH = 32;

  localparam logic [1:0] MA_IDLE    = 2'd0;
  localparam logic [1:0] MA_IF_WAIT = 2'd1;
  localparam logic [1:0] MA_DM_WAIT = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of DM grants won while a fetch was left waiting.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = ($clog2(LIMIT + 1) > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT));

  // Clear wins over increment; hold at LIMIT once reached.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && !at_limit) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM-stage
// load/store port. One access in flight at a time; completions come back as
// one-cycle valid pulses, and the stalls are derived combinationally from them.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DWIDTH       = MA_DWIDTH,
  parameter int PC_WIDTH     = MA_PC_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                ma_clk,
  input  logic                ma_rst,
  input  logic                ma_i_if_req,
  input  logic [PC_WIDTH-1:0] ma_i_if_addr,
  input  logic                ma_i_if_flush,
  output logic                ma_o_if_valid,
  output logic [DWIDTH-1:0]   ma_o_if_instr,
  output logic                ma_o_if_stall,
  input  logic                ma_i_dm_req,
  input  logic                ma_i_dm_we,
  input  logic [PC_WIDTH-1:0] ma_i_dm_addr,
  input  logic [3:0]          ma_i_dm_mask,
  input  logic [DWIDTH-1:0]   ma_i_dm_wdata,
  output logic                ma_o_dm_valid,
  output logic [DWIDTH-1:0]   ma_o_dm_rdata,
  output logic                ma_o_dm_stall,
  output logic                ma_o_mem_req,
  output logic                ma_o_mem_we,
  output logic [PC_WIDTH-1:0] ma_o_mem_addr,
  output logic [3:0]          ma_o_mem_mask,
  output logic [DWIDTH-1:0]   ma_o_mem_wdata,
  input  logic                ma_i_mem_ready,
  input  logic [DWIDTH-1:0]   ma_i_mem_rdata
);

  logic [1:0] state;
  logic       discard;
  logic       at_limit;
  logic       idle;
  logic       grant_if;
  logic       grant_dm;

  // A flushed fetch is never granted; DM normally wins unless IF has waited too long.
  assign idle     = (state == MA_IDLE);
  assign grant_if = idle & ma_i_if_req & ~ma_i_if_flush & (~ma_i_dm_req | at_limit);
  assign grant_dm = idle & ma_i_dm_req & ~grant_if;

  assign ma_o_if_stall = ma_i_if_req & ~ma_o_if_valid;
  assign ma_o_dm_stall = ma_i_dm_req & ~ma_o_dm_valid;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (ma_clk),
    .rst      (ma_rst),
    .inc      (grant_dm & ma_i_if_req),
    .clr      (grant_if | ~ma_i_if_req),
    .at_limit (at_limit)
  );

  // Grant from IDLE, hold the memory request until ready, then pulse the matching valid.
  always_ff @(posedge ma_clk) begin
    if (ma_rst) begin
      state          <= MA_IDLE;
      discard        <= 1'b0;
      ma_o_mem_req   <= 1'b0;
      ma_o_mem_we    <= 1'b0;
      ma_o_mem_addr  <= '0;
      ma_o_mem_mask  <= '0;
      ma_o_mem_wdata <= '0;
      ma_o_if_valid  <= 1'b0;
      ma_o_if_instr  <= '0;
      ma_o_dm_valid  <= 1'b0;
      ma_o_dm_rdata  <= '0;
    end else begin
      ma_o_if_valid <= 1'b0;
      ma_o_dm_valid <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (grant_if) begin
            state          <= MA_IF_WAIT;
            ma_o_mem_req   <= 1'b1;
            ma_o_mem_we    <= 1'b0;
            ma_o_mem_addr  <= ma_i_if_addr;
            ma_o_mem_mask  <= 4'hF;
            ma_o_mem_wdata <= '0;
          end else if (grant_dm) begin
            state          <= MA_DM_WAIT;
            ma_o_mem_req   <= 1'b1;
            ma_o_mem_we    <= ma_i_dm_we;
            ma_o_mem_addr  <= ma_i_dm_addr;
            ma_o_mem_mask  <= ma_i_dm_mask;
            ma_o_mem_wdata <= ma_i_dm_wdata;
          end
        end
        MA_IF_WAIT: begin
          if (ma_i_if_flush) discard <= 1'b1;
          // A flush landing on the ready cycle still squashes the pulse.
          if (ma_i_mem_ready) begin
            state         <= MA_IDLE;
            ma_o_mem_req  <= 1'b0;
            discard       <= 1'b0;
            ma_o_if_valid <= ~(discard | ma_i_if_flush);
            ma_o_if_instr <= ma_i_mem_rdata;
          end
        end
        MA_DM_WAIT: begin
          if (ma_i_mem_ready) begin
            state         <= MA_IDLE;
            ma_o_mem_req  <= 1'b0;
            ma_o_dm_valid <= 1'b1;
            ma_o_dm_rdata <= ma_o_mem_we ? '0 : ma_i_mem_rdata;
          end
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants and completions into queues,
// independent monitors pop and compare whenever the DUT presents them.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          ma_clk = 1'b0;
  logic          ma_rst;
  logic          ma_i_if_req, ma_i_if_flush;
  logic [AW-1:0] ma_i_if_addr;
  logic          ma_o_if_valid, ma_o_if_stall;
  logic [DW-1:0] ma_o_if_instr;
  logic          ma_i_dm_req, ma_i_dm_we;
  logic [AW-1:0] ma_i_dm_addr;
  logic [3:0]    ma_i_dm_mask;
  logic [DW-1:0] ma_i_dm_wdata;
  logic          ma_o_dm_valid, ma_o_dm_stall;
  logic [DW-1:0] ma_o_dm_rdata;
  logic          ma_o_mem_req, ma_o_mem_we;
  logic [AW-1:0] ma_o_mem_addr;
  logic [3:0]    ma_o_mem_mask;
  logic [DW-1:0] ma_o_mem_wdata;
  logic          ma_i_mem_ready;
  logic [DW-1:0] ma_i_mem_rdata;

  always #5 ma_clk = ~ma_clk;

  mem_port_arbiter #(.DWIDTH(DW), .PC_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .ma_clk(ma_clk), .ma_rst(ma_rst),
    .ma_i_if_req(ma_i_if_req), .ma_i_if_addr(ma_i_if_addr), .ma_i_if_flush(ma_i_if_flush),
    .ma_o_if_valid(ma_o_if_valid), .ma_o_if_instr(ma_o_if_instr), .ma_o_if_stall(ma_o_if_stall),
    .ma_i_dm_req(ma_i_dm_req), .ma_i_dm_we(ma_i_dm_we), .ma_i_dm_addr(ma_i_dm_addr),
    .ma_i_dm_mask(ma_i_dm_mask), .ma_i_dm_wdata(ma_i_dm_wdata),
    .ma_o_dm_valid(ma_o_dm_valid), .ma_o_dm_rdata(ma_o_dm_rdata), .ma_o_dm_stall(ma_o_dm_stall),
    .ma_o_mem_req(ma_o_mem_req), .ma_o_mem_we(ma_o_mem_we), .ma_o_mem_addr(ma_o_mem_addr),
    .ma_o_mem_mask(ma_o_mem_mask), .ma_o_mem_wdata(ma_o_mem_wdata),
    .ma_i_mem_ready(ma_i_mem_ready), .ma_i_mem_rdata(ma_i_mem_rdata)
  );

  typedef struct {
    bit            is_dm;
    bit            we;
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic [DW-1:0] wdata;
  } grant_t;

  grant_t        exp_grant[$];
  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_dm[$];

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 2;
  int wait_cnt = 0;
  bit stray_ready = 1'b0;
  int cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic grant_t g(input bit is_dm, input bit we, input logic [AW-1:0] a,
                               input logic [3:0] m, input logic [DW-1:0] d);
    grant_t r;
    r.is_dm = is_dm; r.we = we; r.addr = a; r.mask = m; r.wdata = d;
    return r;
  endfunction

  // Backing memory contents: two fixed words, everything else addr ^ A5A50000.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      32'h40:  return 32'h2001000A;
      32'h80:  return 32'h8C220004;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  // Memory responder: ready pulse mem_lat negedges after mem_req is first seen.
  initial begin
    ma_i_mem_ready = 1'b0;
    ma_i_mem_rdata = '0;
    forever begin
      @(negedge ma_clk);
      if (ma_i_mem_ready) begin
        ma_i_mem_ready = 1'b0;
        ma_i_mem_rdata = '0;
        wait_cnt = 0;
      end else if (stray_ready) begin
        stray_ready    = 1'b0;
        ma_i_mem_ready = 1'b1;
        ma_i_mem_rdata = 32'hDEADBEEF;
      end else if (ma_o_mem_req) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          ma_i_mem_ready = 1'b1;
          ma_i_mem_rdata = mem_word(ma_o_mem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor.
  initial forever begin
    @(negedge ma_clk);
    if (ma_o_if_valid) begin
      if (exp_if.size() == 0) flag("if_valid_unexpected");
      else chk("if_instr", ma_o_if_instr, exp_if.pop_front());
    end
    if (ma_o_dm_valid) begin
      if (exp_dm.size() == 0) flag("dm_valid_unexpected");
      else chk("dm_rdata", ma_o_dm_rdata, exp_dm.pop_front());
    end
  end

  // Grant monitor: order of grants plus stability of the request while it is held.
  initial begin
    bit     prev = 1'b0;
    bit     have = 1'b0;
    grant_t cur;
    forever begin
      @(negedge ma_clk);
      if (ma_o_mem_req) begin
        if (!prev) begin
          if (exp_grant.size() == 0) begin
            flag("grant_unexpected");
            have = 1'b0;
          end else begin
            cur  = exp_grant.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("mem_addr", ma_o_mem_addr, cur.addr);
          chk("mem_we", 32'(ma_o_mem_we), 32'(cur.we));
          if (cur.is_dm) begin
            chk("mem_mask", 32'(ma_o_mem_mask), 32'(cur.mask));
            chk("mem_wdata", ma_o_mem_wdata, cur.wdata);
          end
        end
      end
      prev = ma_o_mem_req;
    end
  end

  task automatic if_access(input logic [AW-1:0] a, input logic [DW-1:0] e, output int n);
    exp_if.push_back(e);
    ma_i_if_addr = a;
    ma_i_if_req  = 1'b1;
    n = 0;
    forever begin
      @(negedge ma_clk);
      n++;
      if (ma_o_if_valid) begin
        chk("if_stall_at_valid", 32'(ma_o_if_stall), 32'd0);
        break;
      end
      chk("if_stall_pending", 32'(ma_o_if_stall), 32'd1);
      if (n >= 60) begin flag("if_timeout"); break; end
    end
    ma_i_if_req = 1'b0;
  endtask

  task automatic dm_access(input bit we, input logic [AW-1:0] a, input logic [3:0] m,
                           input logic [DW-1:0] d, input logic [DW-1:0] e);
    int n;
    exp_dm.push_back(e);
    ma_i_dm_we = we; ma_i_dm_addr = a; ma_i_dm_mask = m; ma_i_dm_wdata = d;
    ma_i_dm_req = 1'b1;
    n = 0;
    forever begin
      @(negedge ma_clk);
      n++;
      if (ma_o_dm_valid) begin
        chk("dm_stall_at_valid", 32'(ma_o_dm_stall), 32'd0);
        break;
      end
      chk("dm_stall_pending", 32'(ma_o_dm_stall), 32'd1);
      if (n >= 60) begin flag("dm_timeout"); break; end
    end
    ma_i_dm_req = 1'b0;
  endtask

  task automatic wait_mem_req(input bit lvl, input string name);
    int n = 0;
    while (ma_o_mem_req !== lvl) begin
      @(negedge ma_clk);
      n++;
      if (n >= 40) begin flag(name); break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ma_rst = 1'b1;
    ma_i_if_req = 1'b1; ma_i_if_addr = 32'h44; ma_i_if_flush = 1'b0;
    ma_i_dm_req = 1'b1; ma_i_dm_we = 1'b0; ma_i_dm_addr = 32'h24;
    ma_i_dm_mask = 4'hF; ma_i_dm_wdata = '0;

    // 1: reset state with both requests up, then DM wins the first grant.
    repeat (3) @(negedge ma_clk);
    chk("rst_mem_req", 32'(ma_o_mem_req), 32'd0);
    chk("rst_mem_we", 32'(ma_o_mem_we), 32'd0);
    chk("rst_mem_addr", ma_o_mem_addr, 32'd0);
    chk("rst_mem_mask", 32'(ma_o_mem_mask), 32'd0);
    chk("rst_mem_wdata", ma_o_mem_wdata, 32'd0);
    chk("rst_if_valid", 32'(ma_o_if_valid), 32'd0);
    chk("rst_if_instr", ma_o_if_instr, 32'd0);
    chk("rst_dm_valid", 32'(ma_o_dm_valid), 32'd0);
    chk("rst_dm_rdata", ma_o_dm_rdata, 32'd0);
    exp_grant.push_back(g(1, 0, 32'h24, 4'hF, 32'h0));
    exp_grant.push_back(g(0, 0, 32'h44, 4'hF, 32'h0));
    ma_rst = 1'b0;
    chk("rel_mem_req_low", 32'(ma_o_mem_req), 32'd0);
    fork
      dm_access(0, 32'h24, 4'hF, 32'h0, 32'hA5A50024);
      begin int n1; if_access(32'h44, 32'hA5A50044, n1); end
      begin
        @(negedge ma_clk);
        chk("first_grant_req", 32'(ma_o_mem_req), 32'd1);
        chk("first_grant_addr", ma_o_mem_addr, 32'h24);
      end
    join

    // 2: IF-only fetch, memory answers after 2 cycles.
    exp_grant.push_back(g(0, 0, 32'h40, 4'hF, 32'h0));
    if_access(32'h40, 32'h2001000A, cyc);
    chk("if_latency", 32'(cyc), 32'd3);

    // 3: store returns zero read data.
    mem_lat = 3;
    exp_grant.push_back(g(1, 1, 32'h10, 4'b0011, 32'hBEEF));
    dm_access(1, 32'h10, 4'b0011, 32'hBEEF, 32'h0);

    // 4: both requests held; IF forced through after four DM grants.
    mem_lat = 2;
    exp_grant.push_back(g(1, 0, 32'h100, 4'hF, 32'h0));
    exp_grant.push_back(g(1, 0, 32'h104, 4'hF, 32'h0));
    exp_grant.push_back(g(1, 0, 32'h108, 4'hF, 32'h0));
    exp_grant.push_back(g(1, 0, 32'h10C, 4'hF, 32'h0));
    exp_grant.push_back(g(0, 0, 32'h300, 4'hF, 32'h0));
    exp_grant.push_back(g(1, 0, 32'h110, 4'hF, 32'h0));
    exp_grant.push_back(g(0, 0, 32'h304, 4'hF, 32'h0));
    fork
      begin
        dm_access(0, 32'h100, 4'hF, 32'h0, 32'hA5A50100);
        dm_access(0, 32'h104, 4'hF, 32'h0, 32'hA5A50104);
        dm_access(0, 32'h108, 4'hF, 32'h0, 32'hA5A50108);
        dm_access(0, 32'h10C, 4'hF, 32'h0, 32'hA5A5010C);
        dm_access(0, 32'h110, 4'hF, 32'h0, 32'hA5A50110);
      end
      begin
        int n2;
        if_access(32'h300, 32'hA5A50300, n2);
        if_access(32'h304, 32'hA5A50304, n2);
      end
    join

    // 5: flush in IF_WAIT squashes the pulse; flush in IDLE blocks the grant.
    mem_lat = 4;
    exp_grant.push_back(g(0, 0, 32'h200, 4'hF, 32'h0));
    ma_i_if_addr = 32'h200;
    ma_i_if_req  = 1'b1;
    wait_mem_req(1'b1, "flush_grant_timeout");
    ma_i_if_flush = 1'b1;
    @(negedge ma_clk);
    ma_i_if_flush = 1'b0;
    ma_i_if_req   = 1'b0;
    wait_mem_req(1'b0, "flush_complete_timeout");
    repeat (2) @(negedge ma_clk);
    mem_lat = 2;
    ma_i_if_addr  = 32'h80;
    ma_i_if_req   = 1'b1;
    ma_i_if_flush = 1'b1;
    @(negedge ma_clk);
    chk("idle_flush_blocks", 32'(ma_o_mem_req), 32'd0);
    chk("idle_flush_stall", 32'(ma_o_if_stall), 32'd1);
    ma_i_if_flush = 1'b0;
    exp_grant.push_back(g(0, 0, 32'h80, 4'hF, 32'h0));
    if_access(32'h80, 32'h8C220004, cyc);

    // 6: reset in DM_WAIT abandons the access; stray ready afterwards is ignored.
    mem_lat = 20;
    exp_grant.push_back(g(1, 0, 32'h30, 4'hF, 32'h0));
    ma_i_dm_we = 1'b0; ma_i_dm_addr = 32'h30; ma_i_dm_mask = 4'hF; ma_i_dm_wdata = '0;
    ma_i_dm_req = 1'b1;
    wait_mem_req(1'b1, "rst_grant_timeout");
    @(negedge ma_clk);
    ma_rst = 1'b1;
    ma_i_dm_req = 1'b0;
    @(negedge ma_clk);
    chk("midrst_mem_req", 32'(ma_o_mem_req), 32'd0);
    chk("midrst_dm_valid", 32'(ma_o_dm_valid), 32'd0);
    ma_rst = 1'b0;
    stray_ready = 1'b1;
    repeat (4) begin
      @(negedge ma_clk);
      chk("stray_mem_req", 32'(ma_o_mem_req), 32'd0);
      chk("stray_dm_valid", 32'(ma_o_dm_valid), 32'd0);
    end
    mem_lat = 2;
    exp_grant.push_back(g(1, 0, 32'h34, 4'hF, 32'h0));
    dm_access(0, 32'h34, 4'hF, 32'h0, 32'hA5A50034);

    repeat (3) @(negedge ma_clk);
    chk("grants_left", 32'(exp_grant.size()), 32'd0);
    chk("if_left", 32'(exp_if.size()), 32'd0);
    chk("dm_left", 32'(exp_dm.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
